// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch-side instruction register and its field decoder.
package cpu_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StDone,
        StErr
    } fetch_state_e;

    localparam int unsigned OPC_MSB        = 31;
    localparam int unsigned RS_MSB         = 25;
    localparam int unsigned RT_MSB         = 20;
    localparam int unsigned IMM_MSB        = 15;
    localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/instr_field_decode.sv
// Combinational field split of a 32-bit instruction; shared with the decode stage.
module instr_field_decode
    import cpu_pkg::*;
(
    input  logic [31:0] ir,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [15:0] imm16
);

    assign opcode = ir[OPC_MSB -: 6];
    assign rs     = ir[RS_MSB -: 5];
    assign rt     = ir[RT_MSB -: 5];
    assign imm16  = ir[IMM_MSB -: 16];

endmodule

// File: rtl/instr_byte_assembler.sv
// Instruction register that assembles a big-endian word from four byte reads and holds it.
module instr_byte_assembler
    import cpu_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        fetch_start,
    input  logic [31:0] pc,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_byte,
    input  logic        mem_valid,
    output logic [31:0] ir,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [15:0] imm16,
    output logic        ir_valid,
    output logic        busy,
    output logic        fetch_error
);

    localparam int unsigned BeatW = $clog2(BYTES_PER_WORD);
    localparam logic [BeatW-1:0] LastBeat = BeatW'(BYTES_PER_WORD - 1);
    localparam logic [3:0] WaitLimit = 4'(MAX_WAIT);

    fetch_state_e     state_q, state_d;
    logic [31:0]      base_q, base_d;
    logic [31:0]      ir_q, ir_d;
    logic [BeatW-1:0] beat_q, beat_d;
    logic [3:0]       wait_q, wait_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            base_q  <= '0;
            ir_q    <= '0;
            beat_q  <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            ir_q    <= ir_d;
            beat_q  <= beat_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        ir_d    = ir_q;
        beat_d  = beat_q;
        wait_d  = wait_q;
        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (fetch_start) begin
                    base_d  = {pc[31:2], 2'b00};
                    beat_d  = '0;
                    wait_d  = '0;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                if (mem_valid) begin
                    // Beat 0 lands in the most significant byte.
                    unique case (beat_q)
                        2'd0:    ir_d[31:24] = mem_byte;
                        2'd1:    ir_d[23:16] = mem_byte;
                        2'd2:    ir_d[15:8]  = mem_byte;
                        default: ir_d[7:0]   = mem_byte;
                    endcase
                    wait_d = '0;
                    if (beat_q == LastBeat) begin
                        state_d = StDone;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end else if (wait_q == WaitLimit) begin
                    state_d = StErr;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mem_rd      = (state_q == StFetch);
        busy        = (state_q == StFetch);
        ir_valid    = (state_q == StDone);
        fetch_error = (state_q == StErr);
        mem_addr    = '0;
        if (state_q == StFetch) begin
            mem_addr = base_q + {{(32 - BeatW){1'b0}}, beat_q};
        end
    end

    assign ir = ir_q;

    instr_field_decode u_field_decode (
        .ir     (ir_q),
        .opcode (opcode),
        .rs     (rs),
        .rt     (rt),
        .imm16  (imm16)
    );

endmodule

// File: tb/tb_instr_byte_assembler.sv
// Directed bench for instr_byte_assembler with a byte-memory responder and word scoreboard.
module tb_instr_byte_assembler;

    logic        clk;
    logic        reset_n;
    logic        fetch_start;
    logic [31:0] pc;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_byte;
    logic        mem_valid;
    logic [31:0] ir;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm16;
    logic        ir_valid;
    logic        busy;
    logic        fetch_error;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  mem [logic [31:0]];
    logic [31:0] sb_q [$];
    logic        mem_en     = 1'b1;
    int          stall_req  = 0;
    logic [31:0] stall_addr = '0;

    instr_byte_assembler dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .fetch_start (fetch_start),
        .pc          (pc),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .mem_byte    (mem_byte),
        .mem_valid   (mem_valid),
        .ir          (ir),
        .opcode      (opcode),
        .rs          (rs),
        .rt          (rt),
        .imm16       (imm16),
        .ir_valid    (ir_valid),
        .busy        (busy),
        .fetch_error (fetch_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory responder: answers reads on the falling edge, optionally stalling one address.
    initial begin
        int stalled;
        stalled   = 0;
        mem_valid = 1'b0;
        mem_byte  = 8'h00;
        forever begin
            @(negedge clk);
            if (fetch_start) stalled = 0;
            if (mem_rd && mem_en) begin
                if (stalled < stall_req && mem_addr == stall_addr) begin
                    stalled++;
                    mem_valid = 1'b0;
                end else begin
                    mem_valid = 1'b1;
                    mem_byte  = mem.exists(mem_addr) ? mem[mem_addr] : 8'h00;
                end
            end else begin
                mem_valid = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic start_fetch(input logic [31:0] addr, input logic [31:0] word);
        pc          = addr;
        fetch_start = 1'b1;
        sb_q.push_back(word);
        step();
        fetch_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max_cyc);
        int n;
        n = 0;
        while (!ir_valid && n < max_cyc) begin
            step();
            n++;
        end
        check({tag, "_reached_done"}, 32'(ir_valid), 32'd1);
    endtask

    task automatic sb_compare(input string tag);
        logic [31:0] w;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd1);
        end else begin
            w = sb_q.pop_front();
            check({tag, "_ir"},     ir,                  w);
            check({tag, "_opcode"}, 32'(opcode),         32'(w[31:26]));
            check({tag, "_rs"},     32'(rs),             32'(w[25:21]));
            check({tag, "_rt"},     32'(rt),             32'(w[20:16]));
            check({tag, "_imm16"},  32'(imm16),          32'(w[15:0]));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_addr"}, mem_addr, 32'h0);
        check({tag, "_mem_rd"},   32'(mem_rd), 32'd0);
        check({tag, "_ir"},       ir, 32'h0);
        check({tag, "_ir_valid"}, 32'(ir_valid), 32'd0);
        check({tag, "_busy"},     32'(busy), 32'd0);
        check({tag, "_ferr"},     32'(fetch_error), 32'd0);
    endtask

    initial begin
        int n_rd;
        int n;
        reset_n     = 1'b0;
        fetch_start = 1'b0;
        pc          = '0;
        mem[32'h40] = 8'h8C; mem[32'h41] = 8'h49; mem[32'h42] = 8'h92; mem[32'h43] = 8'h49;
        mem[32'h44] = 8'h00; mem[32'h45] = 8'h00; mem[32'h46] = 8'h52; mem[32'h47] = 8'h48;
        mem[32'h100] = 8'hDE; mem[32'h101] = 8'hAD; mem[32'h102] = 8'hBE; mem[32'h103] = 8'hEF;

        // Reset, then idle with no start.
        step();
        check_reset_outputs("rst");
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle_ir", ir, 32'h0);
            check("idle_imm16", 32'(imm16), 32'h0);
            check("idle_ir_valid", 32'(ir_valid), 32'd0);
            check("idle_mem_rd", 32'(mem_rd), 32'd0);
        end

        // Back-to-back fetch, memory ready every cycle.
        start_fetch(32'h40, 32'h8C499249);
        for (int i = 0; i < 4; i++) begin
            check("b2b_mem_addr", mem_addr, 32'h40 + 32'(i));
            check("b2b_ir_valid_low", 32'(ir_valid), 32'd0);
            step();
        end
        check("b2b_ir_valid_c5", 32'(ir_valid), 32'd1);
        check("b2b_opcode_const", 32'(opcode), 32'h23);
        check("b2b_rs_const", 32'(rs), 32'd2);
        check("b2b_rt_const", 32'(rt), 32'd9);
        check("b2b_imm_const", 32'(imm16), 32'h9249);
        sb_compare("b2b");
        step();
        check("done_holds", 32'(ir_valid), 32'd1);

        // Stalled beat 2: three cycles without mem_valid.
        stall_addr = 32'h42;
        stall_req  = 3;
        start_fetch(32'h40, 32'h8C499249);
        check("stall_valid_drop", 32'(ir_valid), 32'd0);
        step();
        step();
        for (int i = 0; i < 4; i++) begin
            check("stall_addr_hold", mem_addr, 32'h42);
            step();
        end
        check("stall_beat3_addr", mem_addr, 32'h43);
        check("stall_not_done", 32'(ir_valid), 32'd0);
        step();
        check("stall_done_c8", 32'(ir_valid), 32'd1);
        sb_compare("stall");
        stall_req = 0;

        // Timeout with no memory response.
        mem_en = 1'b0;
        pc          = 32'h100;
        fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        n_rd = 0;
        n    = 0;
        while (!fetch_error && n < 40) begin
            if (mem_rd) n_rd++;
            step();
            n++;
        end
        check("to_flag", 32'(fetch_error), 32'd1);
        check("to_fetch_cycles", 32'(n_rd), 32'd16);
        check("to_mem_rd", 32'(mem_rd), 32'd0);
        check("to_ir_valid", 32'(ir_valid), 32'd0);
        step();
        step();
        check("to_sticky", 32'(fetch_error), 32'd1);

        // Restart clears the flag; mem_valid arriving on the limit cycle still wins.
        mem_en     = 1'b1;
        stall_addr = 32'h100;
        stall_req  = 15;
        start_fetch(32'h100, 32'hDEADBEEF);
        check("rs_flag_clear", 32'(fetch_error), 32'd0);
        check("rs_addr", mem_addr, 32'h100);
        for (int i = 0; i < 16; i++) step();
        check("limit_no_err", 32'(fetch_error), 32'd0);
        check("limit_advanced", mem_addr, 32'h101);
        wait_done("limit", 10);
        sb_compare("limit");
        stall_req = 0;

        // Reset asserted after beat 1.
        start_fetch(32'h40, 32'h8C499249);
        step();
        step();
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        sb_q.delete();
        step();
        check("midrst_no_rd", 32'(mem_rd), 32'd0);
        reset_n = 1'b1;
        step();

        // Misaligned pc is forced to word alignment.
        start_fetch(32'h103, 32'hDEADBEEF);
        check("misalign_addr", mem_addr, 32'h100);
        wait_done("misalign", 10);
        sb_compare("misalign");

        // Refetch from DONE, with a start pulse during FETCH that must be ignored.
        start_fetch(32'h44, 32'h00005248);
        check("refetch_valid_drop", 32'(ir_valid), 32'd0);
        check("refetch_old_ir", ir, 32'hDEADBEEF);
        step();
        pc          = 32'h40;
        fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        check("ignored_start_addr", mem_addr, 32'h46);
        check("ignored_start_err", 32'(fetch_error), 32'd0);
        wait_done("refetch", 10);
        sb_compare("refetch");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_byte_assembler.md
Name: instr_byte_assembler

Overview:
- Fetch-side instruction register for the multicycle datapath.
- Reads a 32-bit instruction from byte-wide memory in four big-endian beats and holds it stable.
- Exposes decoded fields opcode, rs, rt and imm16. imm16 is the direct feed of the sign-extend stage.
- Sits between the memory port and the decode/sign-extend logic. The control unit starts it per fetch and waits for ir_valid.

Parameters:
- MAX_WAIT, 15, cycles allowed per beat without mem_valid before fetch_error; counter width 4 bits.
- BYTES_PER_WORD, 4, beats per instruction; fixed at 4, not for override.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- fetch_start  input  1  one-cycle pulse from control; launches a fetch of word at pc
- pc  input  32  word address, sampled on fetch_start; bits [1:0] ignored (treated as 0)
- mem_addr  output  32  byte address of current beat
- mem_rd  output  1  read request; high while in FETCH
- mem_byte  input  8  read data
- mem_valid  input  1  mem_byte valid this cycle for mem_addr
- ir  output  32  assembled instruction
- opcode  output  6  ir[31:26]
- rs  output  5  ir[25:21]
- rt  output  5  ir[20:16]
- imm16  output  16  ir[15:0], to sign-extend stage
- ir_valid  output  1  ir holds a complete, fresh word
- busy  output  1  high in FETCH
- fetch_error  output  1  sticky timeout flag; cleared by next accepted fetch_start

Behaviour:
- Reset (async, reset_n=0): state IDLE; ir=0; beat=0; wait_cnt=0; base_addr=0.
- Outputs during reset: mem_addr=0, mem_rd=0, ir_valid=0, busy=0, fetch_error=0. opcode/rs/rt/imm16 are all 0 because they are slices of ir.
- States: IDLE, FETCH, DONE, ERR.
- IDLE, fetch_start=1:
  - capture base_addr={pc[31:2],2'b00}
  - beat=0, wait_cnt=0, clear fetch_error
  - go to FETCH
- FETCH:
  - mem_rd=1, busy=1, mem_addr=base_addr+beat.
  - On mem_valid: write mem_byte into ir[31-8*beat -: 8] (beat 0 → MSB, big-endian) and reset wait_cnt.
  - If beat==3 on that mem_valid → DONE; otherwise beat increments.
  - Without mem_valid: wait_cnt increments.
  - If wait_cnt==MAX_WAIT with no mem_valid → ERR.
  - A mem_valid in the same cycle as the limit wins; there is no error.
- DONE:
  - ir_valid=1; ir and fields held stable.
  - fetch_start=1 → behaves as in IDLE and ir_valid drops next cycle. Old ir stays visible until overwritten byte-by-byte.
  - Otherwise DONE persists.
- ERR:
  - fetch_error=1, ir_valid=0, mem_rd=0.
  - fetch_start → restart as in IDLE.
- fetch_start during FETCH is ignored; no restart and no error.
- Latency with mem_valid every cycle: fetch_start at cycle 0 gives beats at cycles 1–4 and ir_valid=1 from cycle 5.
- mem_valid outside FETCH is ignored.
- Partially written ir during FETCH is not valid (ir_valid=0). Downstream must gate on ir_valid.
- Address arithmetic is 32-bit modulo. base 0xFFFFFFFC gives beat addresses …FC–…FF with no wrap into beat math.
- Reset asserted mid-FETCH aborts immediately to the reset values; no further memory requests.

Decomposition:
- Shared package (cpu_pkg):
  - state encoding enum for IDLE/FETCH/DONE/ERR
  - field-position constants OPC_MSB=31, RS_MSB=25, RT_MSB=20, IMM_MSB=15
  - BYTES_PER_WORD
- No sub-module required. Field slicing stays inline.
- Optional sub-module: instr_field_decode, purely combinational, reusable by the decode stage.

Test Plan:
- Reset then idle: reset_n=0→1 with no start → ir=0, imm16=0, ir_valid=0, mem_rd=0 for 10 cycles.
- Back-to-back fetch: pc=0x00000040; bytes 0x8C,0x49,0x92,0x49 with mem_valid every cycle:
  - mem_addr steps 0x40,0x41,0x42,0x43
  - from cycle 5: ir=0x8C499249, opcode=0x23, rs=2, rt=9, imm16=0x9249, ir_valid=1
- Stalled memory: same fetch, mem_valid low 3 cycles before beat 2 → mem_addr holds 0x42; completes 3 cycles later with identical ir.
- Timeout: pc=0x100, mem_valid never asserted → fetch_error=1 after MAX_WAIT=15 idle cycles, mem_rd=0. Next fetch_start clears the flag.
- Reset mid-operation and misalignment:
  - reset_n low after beat 1 → all outputs 0 immediately
  - then pc=0x00000103 → mem_addr starts at 0x100
- Refetch from DONE and ignored start:
  - fetch_start with pc=0x44 in DONE → ir_valid=0 next cycle; new word 0x5248 assembled
  - fetch_start pulsed during FETCH → no address restart
